mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the byte-wide CPU memory bus driven by the memory controller.
//  Serves byte reads/writes to an internal RAM and to a small memory-mapped I/O window
//  (TX byte FIFO toward host, RX byte FIFO from host, status). Sits between mc and the
//  board/host I/O; one byte per accepted access, read data valid the next cycle.
// PARAMETERS
//  ADDR_WIDTH  17        RAM index width (2**ADDR_WIDTH bytes)
//  IO_BASE     32'h30000 first I/O address; mem_addr >= IO_BASE selects I/O
//  FIFO_AW     4         log2 depth of each of the TX and RX FIFOs (16 entries)
// PORTS
//  clk_in       in   1   clock
//  rst_in       in   1   reset, synchronous, active-high
//  rdy_in       in   1   global enable; 0 = freeze all state
//  mem_valid    in   1   access strobe: mem_wr/mem_addr/mem_w_data meaningful this cycle
//  mem_wr       in   1   1 = write, 0 = read
//  mem_addr     in   32  byte address
//  mem_w_data   in   8   write byte
//  mem_r_data   out  8   read byte, registered
//  tx_data      out  8   TX FIFO head toward host
//  tx_valid     out  1   TX FIFO non-empty
//  tx_ready     in   1   host accepts tx_data when tx_valid&tx_ready
//  rx_data      in   8   byte from host
//  rx_valid     in   1   host offers rx_data
//  rx_ready     out  1   RX FIFO not full; push when rx_valid&rx_ready
// BEHAVIOUR
//  Reset (rst_in=1 at posedge, overrides rdy_in): mem_r_data=0, FIFO pointers/counts=0,
//   tx_valid=0, rx_ready=1, overflow=0. RAM contents not reset. Reset mid-access drops it.
//  rdy_in=0: no RAM write, no FIFO push/pop on any side, mem_r_data holds.
//  Accepted access = mem_valid & rdy_in & !rst_in. Decode: RAM if mem_addr<IO_BASE,
//   index mem_addr[ADDR_WIDTH-1:0] (upper bits ignored); else I/O, offset mem_addr-IO_BASE.
//  Read latency 1: read accepted at edge t -> mem_r_data valid after edge t, held until
//   next accepted read. Writes update state at the accepting edge; mem_r_data unchanged.
//  RAM read of an address written the same cycle returns OLD byte (read-before-write n/a:
//   access is single-port, one op per cycle).
//  I/O map (offset): 0x0 W push mem_w_data to TX; if TX full -> dropped, overflow<=1.
//   0x0 R  RX head byte, non-destructive; 8'h00 if RX empty.
//   0x4 R  status {5'b0, overflow, rx_nonempty, tx_full}; 0x4 W any value clears overflow.
//   0x8 W  pop RX head; ignored if empty. 0x8 R -> 8'h00. Other offsets: R 8'h00, W ignored.
//  FIFOs: FIFO_AW-bit wrapping pointers plus (FIFO_AW+1)-bit count; full at 2**FIFO_AW.
//   TX: CPU push and host pop same cycle -> both occur, count unchanged; push on full with
//   same-cycle pop still dropped (full evaluated from registered count).
//   RX: host push and CPU pop (0x8) same cycle -> both occur; rx_ready from registered count.
//   tx_data/tx_valid/rx_ready are pure functions of registered FIFO state (no comb path
//   from tx_ready/rx_valid/mem_*).
//  Status/RX reads sample state before the same-edge updates.
// TESTING
//  1 Write 0xA5 to 0x00010, read 0x00010 -> mem_r_data=0xA5 one cycle after read accept.
//  2 Write 0x41,0x42 to 0x30000 with tx_ready=0 -> tx_valid=1, tx_data=0x41; tx_ready=1
//    one cycle -> tx_data=0x42; second pop -> tx_valid=0.
//  3 Fill TX with 16 writes, 17th write 0x99 -> dropped, status read 0x30004 = 8'h05;
//    write 0x30004 -> status 8'h01.
//  4 Host pushes 0x33; read 0x30000 twice -> 0x33 both; write 0x30008 -> status bit1=0,
//    read 0x30000 -> 0x00.
//  5 rdy_in=0 during valid write 0x7E to 0x20 -> RAM[0x20] unchanged; rst_in pulse with
//    TX holding 3 bytes -> tx_valid=0, mem_r_data=0, rx_ready=1 next cycle.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-wide memory responder: RAM plus TX/RX byte FIFO I/O window
// One byte per accepted access; read data is registered and appears after the accepting edge.
module mem_responder #(
   parameter int          ADDR_WIDTH = 17,
   parameter logic [31:0] IO_BASE    = 32'h30000,
   parameter int          FIFO_AW    = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        mem_valid,
   input  logic        mem_wr,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_w_data,
   output logic [7:0]  mem_r_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   logic [7:0]          r_ram [0:(1 << ADDR_WIDTH) - 1];
   logic [7:0]          r_rdata;

   logic [7:0]          r_tx_mem [0:DEPTH - 1];
   logic [FIFO_AW-1:0]  r_tx_wr_ptr;
   logic [FIFO_AW-1:0]  r_tx_rd_ptr;
   logic [FIFO_AW:0]    r_tx_cnt;

   logic [7:0]          r_rx_mem [0:DEPTH - 1];
   logic [FIFO_AW-1:0]  r_rx_wr_ptr;
   logic [FIFO_AW-1:0]  r_rx_rd_ptr;
   logic [FIFO_AW:0]    r_rx_cnt;

   logic                r_overflow;

   logic                w_accept;
   logic                w_is_io;
   logic [31:0]         w_io_off;
   logic [ADDR_WIDTH-1:0] w_ram_idx;
   logic                w_ram_wr;
   logic                w_io_wr_tx;
   logic                w_io_wr_stat;
   logic                w_io_wr_pop;
   logic                w_tx_full;
   logic                w_tx_push;
   logic                w_tx_pop;
   logic                w_rx_nonempty;
   logic                w_rx_push;
   logic                w_rx_pop;
   logic [7:0]          w_io_rdata;

   assign w_accept     = mem_valid & rdy_in;
   assign w_is_io      = (mem_addr >= IO_BASE);
   assign w_io_off     = mem_addr - IO_BASE;
   assign w_ram_idx    = mem_addr[ADDR_WIDTH-1:0];
   assign w_ram_wr     = w_accept & mem_wr & ~w_is_io;
   assign w_io_wr_tx   = w_accept & mem_wr & w_is_io & (w_io_off == 32'h0);
   assign w_io_wr_stat = w_accept & mem_wr & w_is_io & (w_io_off == 32'h4);
   assign w_io_wr_pop  = w_accept & mem_wr & w_is_io & (w_io_off == 32'h8);

   // Full/empty come only from registered counts, so the host-facing handshake has no comb path.
   assign w_tx_full     = (r_tx_cnt == FULL_CNT);
   assign w_tx_push     = w_io_wr_tx & ~w_tx_full;
   assign w_tx_pop      = rdy_in & tx_valid & tx_ready;
   assign w_rx_nonempty = (r_rx_cnt != '0);
   assign w_rx_push     = rdy_in & rx_valid & rx_ready;
   assign w_rx_pop      = w_io_wr_pop & w_rx_nonempty;

   assign tx_valid   = (r_tx_cnt != '0);
   assign tx_data    = r_tx_mem[r_tx_rd_ptr];
   assign rx_ready   = (r_rx_cnt != FULL_CNT);
   assign mem_r_data = r_rdata;

   always_comb begin
      w_io_rdata = 8'h00;
      if (w_io_off == 32'h0) begin
         w_io_rdata = w_rx_nonempty ? r_rx_mem[r_rx_rd_ptr] : 8'h00;
      end else if (w_io_off == 32'h4) begin
         w_io_rdata = {5'b0, r_overflow, w_rx_nonempty, w_tx_full};
      end
   end

   // Storage arrays carry no reset; a write coinciding with reset is simply dropped.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         if (w_ram_wr) begin
            r_ram[w_ram_idx] <= mem_w_data;
         end
         if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= mem_w_data;
         end
         if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= rx_data;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_rdata <= 8'h00;
      end else if (w_accept && !mem_wr) begin
         r_rdata <= w_is_io ? w_io_rdata : r_ram[w_ram_idx];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_tx_wr_ptr <= '0;
         r_tx_rd_ptr <= '0;
         r_tx_cnt    <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_tx_push) begin
            r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
         end
         if (w_tx_pop) begin
            r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
         end
         if (w_tx_push && !w_tx_pop) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
         end else if (!w_tx_push && w_tx_pop) begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
         end
         if (w_io_wr_tx && w_tx_full) begin
            r_overflow <= 1'b1;
         end else if (w_io_wr_stat) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_rx_wr_ptr <= '0;
         r_rx_rd_ptr <= '0;
         r_rx_cnt    <= '0;
      end else begin
         if (w_rx_push) begin
            r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
         end
         if (w_rx_pop) begin
            r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
         end
         if (w_rx_push && !w_rx_pop) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
         end else if (!w_rx_push && w_rx_pop) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        mem_valid;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [7:0]  mem_w_data;
   logic [7:0]  mem_r_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  exp_q[$];
   string       name_q[$];
   logic        r_pend;
   logic [7:0]  mon_exp;
   string       mon_name;

   mem_responder dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .mem_valid  (mem_valid),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      r_pend <= mem_valid && !mem_wr && rdy_in && !rst_in;
   end

   initial begin
      forever begin
         @(negedge clk_in);
         if (r_pend === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected got %02h required none", mem_r_data);
            end else begin
               mon_exp  = exp_q.pop_front();
               mon_name = name_q.pop_front();
               if (mem_r_data !== mon_exp) begin
                  errors++;
                  $display("FAIL %s got %02h required %02h", mon_name, mem_r_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout got running required finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %02h required %02h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
      @(negedge clk_in);
      mem_valid  = 1'b1;
      mem_wr     = 1'b1;
      mem_addr   = addr;
      mem_w_data = data;
      @(negedge clk_in);
      mem_valid  = 1'b0;
      mem_wr     = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [7:0] exp, input string name);
      @(negedge clk_in);
      mem_valid = 1'b1;
      mem_wr    = 1'b0;
      mem_addr  = addr;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(negedge clk_in);
      mem_valid = 1'b0;
   endtask

   task automatic tx_pop_one();
      @(negedge clk_in);
      tx_ready = 1'b1;
      @(negedge clk_in);
      tx_ready = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; mem_valid = 1'b0; mem_wr = 1'b0;
      mem_addr = '0; mem_w_data = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check("rst_r_data", mem_r_data, 8'h00);
      check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
      check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);

      // RAM write/read and upper-bit aliasing
      bus_write(32'h00010, 8'hA5);
      bus_read(32'h00010, 8'hA5, "ram_rd_a5");
      bus_write(32'h20020, 8'h5C);
      bus_read(32'h00020, 8'h5C, "ram_alias");
      bus_read(32'h00010, 8'hA5, "ram_rd_a5_again");

      // TX ordering and host pop
      bus_write(32'h30000, 8'h41);
      bus_write(32'h30000, 8'h42);
      check("tx_valid_2", {7'b0, tx_valid}, 8'h01);
      check("tx_head_41", tx_data, 8'h41);
      tx_pop_one();
      check("tx_head_42", tx_data, 8'h42);
      tx_pop_one();
      check("tx_empty", {7'b0, tx_valid}, 8'h00);

      // TX same-cycle push and pop keeps count
      bus_write(32'h30000, 8'h41);
      @(negedge clk_in);
      mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30000; mem_w_data = 8'h77; tx_ready = 1'b1;
      @(negedge clk_in);
      mem_valid = 1'b0; mem_wr = 1'b0; tx_ready = 1'b0;
      check("tx_pushpop_valid", {7'b0, tx_valid}, 8'h01);
      check("tx_pushpop_head", tx_data, 8'h77);
      tx_pop_one();
      check("tx_pushpop_empty", {7'b0, tx_valid}, 8'h00);

      // TX full, overflow, clear
      for (int i = 0; i < 16; i++) bus_write(32'h30000, 8'(i + 8'h10));
      bus_write(32'h30000, 8'h99);
      bus_read(32'h30004, 8'h05, "stat_full_ovf");
      bus_write(32'h30004, 8'hFF);
      bus_read(32'h30004, 8'h01, "stat_ovf_clr");
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_in);
         check("tx_drain", tx_data, 8'(i + 8'h10));
         tx_ready = 1'b1;
      end
      @(negedge clk_in);
      tx_ready = 1'b0;
      check("tx_drop_99", {7'b0, tx_valid}, 8'h00);
      bus_read(32'h30004, 8'h00, "stat_idle");

      // RX non-destructive read and pop
      @(negedge clk_in);
      rx_data = 8'h33; rx_valid = 1'b1;
      @(negedge clk_in);
      rx_valid = 1'b0;
      bus_read(32'h30000, 8'h33, "rx_head_1");
      bus_read(32'h30000, 8'h33, "rx_head_2");
      bus_read(32'h30004, 8'h02, "stat_rx_ne");
      bus_read(32'h30008, 8'h00, "rd_off8");
      bus_write(32'h30008, 8'h00);
      bus_read(32'h30004, 8'h00, "stat_rx_empty");
      bus_read(32'h30000, 8'h00, "rx_empty_rd");
      bus_read(32'h3000C, 8'h00, "rd_other_off");

      // RX full and same-cycle push/pop
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_in);
         rx_data = 8'(i + 8'h50); rx_valid = 1'b1;
      end
      @(negedge clk_in);
      rx_valid = 1'b0;
      check("rx_full_ready", {7'b0, rx_ready}, 8'h00);
      @(negedge clk_in);
      rx_data = 8'hEE; rx_valid = 1'b1;
      mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30008;
      @(negedge clk_in);
      rx_valid = 1'b0; mem_valid = 1'b0; mem_wr = 1'b0;
      check("rx_ready_after_pop", {7'b0, rx_ready}, 8'h01);
      bus_read(32'h30000, 8'h51, "rx_head_51");
      @(negedge clk_in);
      rx_data = 8'hEE; rx_valid = 1'b1;
      mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 32'h30008;
      @(negedge clk_in);
      rx_valid = 1'b0; mem_valid = 1'b0; mem_wr = 1'b0;
      check("rx_pushpop_ready", {7'b0, rx_ready}, 8'h01);
      bus_read(32'h30000, 8'h52, "rx_head_52");

      // rdy_in freeze and reset
      bus_write(32'h00020, 8'h11);
      @(negedge clk_in);
      rdy_in = 1'b0;
      mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 32'h00020; mem_w_data = 8'h7E;
      @(negedge clk_in);
      mem_valid = 1'b0; mem_wr = 1'b0; rdy_in = 1'b1;
      bus_read(32'h00020, 8'h11, "rdy_freeze_ram");
      for (int i = 0; i < 3; i++) bus_write(32'h30000, 8'(8'hC0 + i));
      check("tx_before_rst", {7'b0, tx_valid}, 8'h01);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("rst2_tx_valid", {7'b0, tx_valid}, 8'h00);
      check("rst2_r_data", mem_r_data, 8'h00);
      check("rst2_rx_ready", {7'b0, rx_ready}, 8'h01);
      bus_read(32'h30004, 8'h00, "rst2_status");

      repeat (3) @(negedge clk_in);
      check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
